gray_fifo_ctrl: RTL and testbench
=================================

Name: gray_fifo_ctrl

Overview:
- Single-clock FIFO pointer controller built around gray-coded pointers.
- Sequences write/read pointer advance (the ce of each pointer counter), derives full/empty/fill level and drives binary RAM addresses.
- Exports gray-coded pointers so a later dual-clock variant can synchronise them without changing the pointer logic.
- Sits between a producer/consumer pair and an external simple dual-port RAM of depth 2**W.

Parameters:
W, 4, address width; FIFO depth = 2**W entries (W >= 2)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
rd_en  in  1  read request
wr_ack  out  1  write accepted this cycle (combinational: wr_en & ~full)
rd_ack  out  1  read accepted this cycle (combinational: rd_en & ~empty)
wr_addr  out  W  RAM write address (binary write pointer, low W bits)
rd_addr  out  W  RAM read address (binary read pointer, low W bits)
wr_ptr_gray  out  W+1  gray-coded write pointer
rd_ptr_gray  out  W+1  gray-coded read pointer
full  out  1  registered full flag
empty  out  1  registered empty flag
usedw  out  W+1  registered fill level, 0..2**W

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk, no asynchronous path.
- Reset values: wr/rd binary pointers 0, both gray pointers 0, wr_addr = rd_addr = 0, empty = 1, full = 0, usedw = 0. The reset cycle overrides wr_en/rd_en.
- Reset mid-operation: all state returns to reset values on the next edge; stored RAM data is abandoned.
- Pointers: internal binary pointers of W+1 bits (extra wrap bit). Each advances by 1 on an accepted op and wraps 2**(W+1)-1 -> 0.
- Gray outputs: registers updated on the same edge as their binary pointer, value = b ^ (b >> 1). Consecutive values differ in exactly one bit, including across the wrap.
- Accept rules use the registered flags of the current cycle:
  - write accepted iff wr_en & ~full
  - read accepted iff rd_en & ~empty
- Latency: an accepted op changes its pointer, addresses, usedw and flags on the next edge. wr_addr/rd_addr show the slot for the current cycle's op (RAM write uses wr_addr while wr_ack = 1). The read slot is rd_addr while rd_ack = 1; RAM read latency is external.
- Flags after each edge (computed from next-state pointers):
  - empty = (next_wr == next_rd)
  - full = (next_wr[W] != next_rd[W]) & (next_wr[W-1:0] == next_rd[W-1:0])
  - usedw = next_wr - next_rd (mod 2**(W+1))
- Simultaneous events:
  - both accepted: both pointers advance; usedw, full and empty unchanged
  - full with wr_en & rd_en: read accepted, write refused; next cycle full = 0, usedw = 2**W - 1
  - empty with wr_en & rd_en: write accepted, read refused; next cycle empty = 0, usedw = 1
- Refused requests have no side effects; the requester must hold or retry.
- Invariants: full and empty never both 1; usedw == 2**W iff full; usedw == 0 iff empty.

Optional Feature:
Macro GRAY_FIFO_CTRL_ERR_EN.
- Defined: adds outputs overflow (1) and underflow (1), each sticky and reset to 0.
  - overflow sets on the edge after any cycle with wr_en & full.
  - underflow sets on the edge after any cycle with rd_en & empty.
  - Both clear only on reset.
  - A refused request during simultaneous-op cases still sets its flag (e.g. full with wr_en & rd_en sets overflow).
- Undefined: ports absent; refused requests are silently dropped, no other behaviour change.

Test Plan (W = 4, depth 16):
- Reset held 3 cycles with wr_en = rd_en = 1 -> after release empty = 1, full = 0, usedw = 0, gray pointers 00000, no ack during reset.
- 16 writes from empty -> usedw counts 1..16, full = 1 after the 16th, 17th wr_en gives wr_ack = 0, wr_addr stays 0; with GRAY_FIFO_CTRL_ERR_EN overflow = 1 next edge.
- 16 reads from full -> rd_addr sequence 0..15, empty = 1 after the last, further rd_en gives rd_ack = 0 and pointers unchanged; with macro underflow = 1.
- wr_en & rd_en at full (usedw = 16) -> rd_ack = 1, wr_ack = 0, next usedw = 15, full = 0. Same at empty -> wr_ack = 1, rd_ack = 0, next usedw = 1, empty = 0.
- Continuous simultaneous write+read at usedw = 5 for 40 cycles -> usedw stays 5, pointers wrap past 31 -> 0. Every wr_ptr_gray/rd_ptr_gray transition differs in exactly one bit, including gray 10000 -> 00000.
- Random wr_en/rd_en for 1000 cycles against a reference count model -> usedw matches the model, and the flag invariants hold every cycle.

Source files
------------

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller with gray-coded pointer exports.
// Optional sticky overflow/underflow outputs enabled by GRAY_FIFO_CTRL_ERR_EN.
module gray_fifo_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic         wr_ack,
  output logic         rd_ack,
  output logic [W-1:0] wr_addr,
  output logic [W-1:0] rd_addr,
  output logic [W:0]   wr_ptr_gray,
  output logic [W:0]   rd_ptr_gray,
  output logic         full,
  output logic         empty,
  output logic [W:0]   usedw
`ifdef GRAY_FIFO_CTRL_ERR_EN
  ,
  output logic         overflow,
  output logic         underflow
`endif
);

  localparam int unsigned PW = W + 1;

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] usedw_nxt;
  logic          full_nxt;
  logic          empty_nxt;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Accept decisions use the current registered flags; reset blocks both ops.
  always_comb begin
    wr_ack    = wr_en & ~full & ~reset;
    rd_ack    = rd_en & ~empty & ~reset;
    wr_nxt    = wr_bin + PW'(wr_ack);
    rd_nxt    = rd_bin + PW'(rd_ack);
    usedw_nxt = wr_nxt - rd_nxt;
    empty_nxt = (wr_nxt == rd_nxt);
    full_nxt  = (wr_nxt[W] != rd_nxt[W]) && (wr_nxt[W-1:0] == rd_nxt[W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin      <= '0;
      rd_bin      <= '0;
      wr_ptr_gray <= '0;
      rd_ptr_gray <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      usedw       <= '0;
    end else begin
      wr_bin      <= wr_nxt;
      rd_bin      <= rd_nxt;
      wr_ptr_gray <= bin2gray(wr_nxt);
      rd_ptr_gray <= bin2gray(rd_nxt);
      full        <= full_nxt;
      empty       <= empty_nxt;
      usedw       <= usedw_nxt;
    end
  end

  assign wr_addr = wr_bin[W-1:0];
  assign rd_addr = rd_bin[W-1:0];

`ifdef GRAY_FIFO_CTRL_ERR_EN
  // Sticky error flags: any refused request latches until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed self-checking bench for gray_fifo_ctrl (W = 4, depth 16).
// Build with GRAY_FIFO_CTRL_ERR_EN defined to also cover overflow/underflow.
module tb_gray_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic       wr_ack;
  logic       rd_ack;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       full;
  logic       empty;
  logic [4:0] usedw;
`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] wp = '0;
  logic [4:0] rp = '0;

  always #5 clk = ~clk;

  gray_fifo_ctrl #(.W(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .full(full), .empty(empty), .usedw(usedw)
`ifdef GRAY_FIFO_CTRL_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
        errors++; $display("FAIL reset_ack: wr_ack=%b rd_ack=%b expected 0 0", wr_ack, rd_ack);
      end
      step();
    end
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || usedw !== 5'd0) begin
      errors++; $display("FAIL reset_flags: empty=%b full=%b usedw=%0d expected 1 0 0", empty, full, usedw);
    end
    checks++;
    if (wr_ptr_gray !== 5'b00000 || rd_ptr_gray !== 5'b00000 || wr_addr !== 4'd0 || rd_addr !== 4'd0) begin
      errors++; $display("FAIL reset_ptrs: wg=%b rg=%b wa=%0d ra=%0d expected all 0", wr_ptr_gray, rd_ptr_gray, wr_addr, rd_addr);
    end
`ifdef GRAY_FIFO_CTRL_ERR_EN
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err: ovf=%b unf=%b expected 0 0", overflow, underflow);
    end
`endif
    wp = '0; rp = '0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      checks++;
      if (wr_ack !== 1'b1 || wr_addr !== wp[3:0]) begin
        errors++; $display("FAIL fill_ack[%0d]: wr_ack=%b wr_addr=%0d expected 1 %0d", i, wr_ack, wr_addr, wp[3:0]);
      end
      step();
      wp = wp + 5'd1;
      checks++;
      if (usedw !== 5'(i + 1) || full !== (i == 15) || empty !== 1'b0) begin
        errors++; $display("FAIL fill_lvl[%0d]: usedw=%0d full=%b empty=%b expected %0d %b 0", i, usedw, full, empty, i + 1, (i == 15));
      end
    end
    #1;
    checks++;
    if (wr_ack !== 1'b0 || wr_addr !== 4'd0) begin
      errors++; $display("FAIL fill_refuse: wr_ack=%b wr_addr=%0d expected 0 0", wr_ack, wr_addr);
    end
    step();
    wr_en = 1'b0;
    checks++;
    if (usedw !== 5'd16 || full !== 1'b1 || wr_addr !== 4'd0 || wr_ptr_gray !== g(wp)) begin
      errors++; $display("FAIL fill_hold: usedw=%0d full=%b wa=%0d wg=%b expected 16 1 0 %b", usedw, full, wr_addr, wr_ptr_gray, g(wp));
    end
`ifdef GRAY_FIFO_CTRL_ERR_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow: got %b expected 1", overflow);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      #1;
      checks++;
      if (rd_ack !== 1'b1 || rd_addr !== 4'(i)) begin
        errors++; $display("FAIL drain_ack[%0d]: rd_ack=%b rd_addr=%0d expected 1 %0d", i, rd_ack, rd_addr, i);
      end
      step();
      rp = rp + 5'd1;
      checks++;
      if (usedw !== 5'(15 - i) || empty !== (i == 15) || full !== 1'b0) begin
        errors++; $display("FAIL drain_lvl[%0d]: usedw=%0d empty=%b full=%b expected %0d %b 0", i, usedw, empty, full, 15 - i, (i == 15));
      end
    end
    #1;
    checks++;
    if (rd_ack !== 1'b0) begin
      errors++; $display("FAIL drain_refuse: rd_ack=%b expected 0", rd_ack);
    end
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_addr !== 4'd0 || rd_ptr_gray !== 5'b11000 || usedw !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL drain_hold: ra=%0d rg=%b usedw=%0d empty=%b expected 0 11000 0 1", rd_addr, rd_ptr_gray, usedw, empty);
    end
`ifdef GRAY_FIFO_CTRL_ERR_EN
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL underflow: got %b expected 1", underflow);
    end
`endif
  endtask

  task automatic test_simul_boundaries();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) step();
    wp = wp + 5'd16;
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++;
    if (rd_ack !== 1'b1 || wr_ack !== 1'b0) begin
      errors++; $display("FAIL full_both_ack: rd_ack=%b wr_ack=%b expected 1 0", rd_ack, wr_ack);
    end
    step();
    rp = rp + 5'd1;
    checks++;
    if (usedw !== 5'd15 || full !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL full_both_lvl: usedw=%0d full=%b empty=%b expected 15 0 0", usedw, full, empty);
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 15; i++) step();
    rp = rp + 5'd15;
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
      errors++; $display("FAIL empty_both_ack: wr_ack=%b rd_ack=%b expected 1 0", wr_ack, rd_ack);
    end
    step();
    wp = wp + 5'd1;
    checks++;
    if (usedw !== 5'd1 || empty !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL empty_both_lvl: usedw=%0d empty=%b full=%b expected 1 0 0", usedw, empty, full);
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rp = rp + 5'd1;
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || usedw !== 5'd0 || wr_ptr_gray !== g(wp) || rd_ptr_gray !== g(rp)) begin
      errors++; $display("FAIL empty_again: empty=%b usedw=%0d wg=%b rg=%b expected 1 0 %b %b", empty, usedw, wr_ptr_gray, rd_ptr_gray, g(wp), g(rp));
    end
  endtask

  task automatic test_wrap();
    logic [4:0] pwg;
    logic [4:0] prg;
    int wraps;
    wraps = 0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    wp = wp + 5'd5;
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pwg = wr_ptr_gray;
      prg = rd_ptr_gray;
      #1;
      checks++;
      if (wr_ack !== 1'b1 || rd_ack !== 1'b1) begin
        errors++; $display("FAIL wrap_ack[%0d]: wr_ack=%b rd_ack=%b expected 1 1", i, wr_ack, rd_ack);
      end
      step();
      wp = wp + 5'd1; rp = rp + 5'd1;
      checks++;
      if (usedw !== 5'd5 || full !== 1'b0 || empty !== 1'b0) begin
        errors++; $display("FAIL wrap_lvl[%0d]: usedw=%0d full=%b empty=%b expected 5 0 0", i, usedw, full, empty);
      end
      checks++;
      if (wr_ptr_gray !== g(wp) || rd_ptr_gray !== g(rp) ||
          $countones(wr_ptr_gray ^ pwg) != 1 || $countones(rd_ptr_gray ^ prg) != 1) begin
        errors++; $display("FAIL wrap_gray[%0d]: wg=%b->%b rg=%b->%b expected %b %b", i, pwg, wr_ptr_gray, prg, rd_ptr_gray, g(wp), g(rp));
      end
      if (pwg == 5'b10000 && wr_ptr_gray == 5'b00000) wraps++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL wrap_seen: wrap transitions=%0d expected 1", wraps);
    end
  endtask

  task automatic test_random();
    int cnt;
    logic ew;
    logic er;
    cnt = 5;
    for (int i = 0; i < 1000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      ew = wr_en && (cnt != 16);
      er = rd_en && (cnt != 0);
      #1;
      checks++;
      if (wr_ack !== ew || rd_ack !== er || wr_addr !== wp[3:0] || rd_addr !== rp[3:0]) begin
        errors++; $display("FAIL rand_ack[%0d]: wa=%b ra=%b waddr=%0d raddr=%0d expected %b %b %0d %0d", i, wr_ack, rd_ack, wr_addr, rd_addr, ew, er, wp[3:0], rp[3:0]);
      end
      step();
      if (ew) begin cnt++; wp = wp + 5'd1; end
      if (er) begin cnt--; rp = rp + 5'd1; end
      checks++;
      if (usedw !== 5'(cnt) || full !== (cnt == 16) || empty !== (cnt == 0) || (full && empty)) begin
        errors++; $display("FAIL rand_lvl[%0d]: usedw=%0d full=%b empty=%b expected %0d %b %b", i, usedw, full, empty, cnt, (cnt == 16), (cnt == 0));
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_simul_boundaries();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
